cpu64_l2_mshr_ctrl: RTL and testbench
=====================================

Name: cpu64_l2_mshr_ctrl

Overview:
Single-transaction sequencer for one cpu64_l2_mshr entry in the L2 coherence agent. Accepts a Get/Acquire from the A-channel front end and allocates the MSHR. Fans out one probe per sharing core on channel B and forwards channel-C probe acks into the MSHR. Issues the D-channel response, waits for E-channel GrantAck where required, then deallocates the MSHR.

Parameters:
ADDR_W, 64, address width
SOURCE_W, 6, TileLink source id width
TYPE_W, 3, request opcode width
CORES, 4, number of cached cores (probe targets)

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted
req_addr_i  in  ADDR_W  line address
req_source_i  in  SOURCE_W  requester source id
req_type_i  in  TYPE_W  opcode: 4=Get, 6=AcquireBlock, 7=AcquirePerm
req_core_i  in  $clog2(CORES)  requesting core index
req_sharers_i  in  CORES  directory sharer mask
mshr_alloc_ready_i  in  1  MSHR free
mshr_alloc_req_o  out  1  MSHR allocate pulse
mshr_alloc_addr_o / mshr_alloc_source_o / mshr_alloc_type_o  out  ADDR_W/SOURCE_W/TYPE_W  allocate fields
mshr_set_probes_o  out  1  load pending mask pulse
mshr_probes_mask_o  out  CORES  pending mask value
mshr_probe_ack_o  out  1  clear-pending pulse
mshr_probe_ack_id_o  out  $clog2(CORES)  core to clear
mshr_pending_probes_i  in  CORES  MSHR pending mask
mshr_dealloc_req_o  out  1  deallocate pulse
probe_valid_o  out  1  B-channel probe valid
probe_ready_i  in  1  B-channel ready
probe_core_o  out  $clog2(CORES)  probe target
probe_addr_o  out  ADDR_W  probe address
probe_cap_o  out  2  1=toB (Get), 2=toN (Acquire*)
pack_valid_i  in  1  C-channel ProbeAck (always accepted)
pack_core_i  in  $clog2(CORES)  acking core
grant_valid_o  out  1  D-channel valid
grant_ready_i  in  1  D-channel ready
grant_opcode_o  out  3  1=AccessAckData, 5=GrantData, 4=Grant
grant_source_o  out  SOURCE_W  response source
gack_valid_i  in  1  E-channel GrantAck
busy_o  out  1  state != IDLE
proto_err_o  out  1  one-cycle pulse on unexpected C/E beat

Behaviour:
- Reset: state IDLE; all outputs and registered fields 0. Reset mid-operation returns to IDLE with no dealloc pulse; the MSHR is reset by the same rst_n.
- States: IDLE, SETP, PROBE, WAIT_ACK, GRANT, WAIT_GACK, FREE.
- IDLE: req_ready_o = mshr_alloc_ready_i. On handshake: mshr_alloc_req_o=1 the same cycle, with alloc fields driven straight from req_*. Latch addr, source, type and core. Latch to_send = req_sharers_i & ~onehot(req_core_i). Go to SETP.
- SETP: pulse mshr_set_probes_o with mask=to_send. Go to PROBE if to_send!=0, else GRANT.
- PROBE: probe_valid_o=1; probe_core_o = lowest set bit of to_send. On probe_valid&probe_ready, clear that bit; when the result is 0, go to WAIT_ACK. Hold outputs stable while ready is low.
- Ack forwarding, PROBE and WAIT_ACK only: pack_valid_i drives mshr_probe_ack_o and mshr_probe_ack_id_o combinationally. A registered copy, ack_q, is held for one cycle.
- WAIT_ACK exit: go to GRANT when mshr_pending_probes_i==0 && !pack_valid_i && !ack_q. This accounts for the MSHR's one-cycle clear latency.
- GRANT: grant_valid_o=1. Opcode 1 for Get, 5 for AcquireBlock, 4 for AcquirePerm. On handshake: Get goes to FREE; Acquire* goes to WAIT_GACK.
- WAIT_GACK: on gack_valid_i go to FREE.
- FREE: pulse mshr_dealloc_req_o for one cycle, then go to IDLE. mshr_alloc_ready_i rises the cycle after.
- pack_valid_i outside PROBE/WAIT_ACK, or gack_valid_i outside WAIT_GACK: dropped, proto_err_o=1 for one cycle.
- A simultaneous probe handshake and ack in the same cycle are both processed.
- An ack for a non-pending core is forwarded anyway and is harmless.
- Minimum Get latency with no probes: accept at t, grant_valid at t+2, dealloc at t+3, req_ready at t+4.

Decomposition:
- Package cpu64_l2_pkg holds: opcode constants (GET=4, ACQ_BLOCK=6, ACQ_PERM=7; D opcodes 1/4/5; CAP_TOB=1, CAP_TON=2) and the state enum.
- One natural sub-module, cpu64_l2_prio_enc: lowest-set-bit encoder with a valid flag, used for probe target selection.

Test Plan:
- Get addr 0x1000, src 0x1A, core 0, sharers 0001, grant_ready=1: no probe_valid; grant opcode 1 at t+2; dealloc at t+3; no gack wait.
- AcquireBlock addr 0x2000, core 1, sharers 1101, probe_ready=1: probes to cores 0, 2, 3 in consecutive cycles with cap=2; mshr mask 1101.
- Same as previous with acks in order 2, 0, 3: pending goes 1101→1001→1000→0000; grant opcode 5 is asserted no earlier than 2 cycles after the last ack.
- probe_ready held low 3 cycles on the first probe: probe_core_o stays 0 and valid stays high; sequence otherwise unchanged.
- AcquirePerm reaches WAIT_GACK; a stray pack_valid_i there gives proto_err_o=1; after gack, dealloc pulses once and req_ready returns high.
- rst_n asserted in WAIT_ACK: all outputs 0 immediately; after release, a new Get is accepted normally.

Source files
------------

// File: rtl/cpu64_l2_pkg.sv
// Shared constants and types for the L2 MSHR transaction sequencer.
package cpu64_l2_pkg;

    // A-channel request opcodes
    localparam logic [2:0] OP_GET       = 3'd4;
    localparam logic [2:0] OP_ACQ_BLOCK = 3'd6;
    localparam logic [2:0] OP_ACQ_PERM  = 3'd7;

    // D-channel response opcodes
    localparam logic [2:0] D_ACCESS_ACK_DATA = 3'd1;
    localparam logic [2:0] D_GRANT           = 3'd4;
    localparam logic [2:0] D_GRANT_DATA      = 3'd5;

    // B-channel probe capabilities
    localparam logic [1:0] CAP_TOB = 2'd1;
    localparam logic [1:0] CAP_TON = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETP,
        ST_PROBE,
        ST_WAIT_ACK,
        ST_GRANT,
        ST_WAIT_GACK,
        ST_FREE
    } mshr_state_e;

    // Response opcode for a given request; any non-Get, non-AcquirePerm
    // request is treated as AcquireBlock.
    function automatic logic [2:0] d_opcode(input logic [2:0] a_opcode);
        case (a_opcode)
            OP_GET:      return D_ACCESS_ACK_DATA;
            OP_ACQ_PERM: return D_GRANT;
            default:     return D_GRANT_DATA;
        endcase
    endfunction

endpackage

// File: rtl/cpu64_l2_prio_enc.sv
// Lowest-set-bit encoder with a valid flag; picks the next probe target.
module cpu64_l2_prio_enc #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  vec,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan from the top so the lowest set bit wins the last assignment
    always_comb begin
        idx   = '0;
        valid = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx   = IW'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cpu64_l2_mshr_ctrl.sv
// Single-transaction sequencer for one L2 MSHR entry: allocate, probe
// sharers, collect probe acks, grant, wait for GrantAck, deallocate.
module cpu64_l2_mshr_ctrl
    import cpu64_l2_pkg::*;
#(
    parameter int ADDR_W   = 64,
    parameter int SOURCE_W = 6,
    parameter int TYPE_W   = 3,
    parameter int CORES    = 4,
    parameter int CORE_W   = $clog2(CORES)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [ADDR_W-1:0]   req_addr_i,
    input  logic [SOURCE_W-1:0] req_source_i,
    input  logic [TYPE_W-1:0]   req_type_i,
    input  logic [CORE_W-1:0]   req_core_i,
    input  logic [CORES-1:0]    req_sharers_i,
    input  logic                mshr_alloc_ready_i,
    output logic                mshr_alloc_req_o,
    output logic [ADDR_W-1:0]   mshr_alloc_addr_o,
    output logic [SOURCE_W-1:0] mshr_alloc_source_o,
    output logic [TYPE_W-1:0]   mshr_alloc_type_o,
    output logic                mshr_set_probes_o,
    output logic [CORES-1:0]    mshr_probes_mask_o,
    output logic                mshr_probe_ack_o,
    output logic [CORE_W-1:0]   mshr_probe_ack_id_o,
    input  logic [CORES-1:0]    mshr_pending_probes_i,
    output logic                mshr_dealloc_req_o,
    output logic                probe_valid_o,
    input  logic                probe_ready_i,
    output logic [CORE_W-1:0]   probe_core_o,
    output logic [ADDR_W-1:0]   probe_addr_o,
    output logic [1:0]          probe_cap_o,
    input  logic                pack_valid_i,
    input  logic [CORE_W-1:0]   pack_core_i,
    output logic                grant_valid_o,
    input  logic                grant_ready_i,
    output logic [2:0]          grant_opcode_o,
    output logic [SOURCE_W-1:0] grant_source_o,
    input  logic                gack_valid_i,
    output logic                busy_o,
    output logic                proto_err_o
);

    mshr_state_e         state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [SOURCE_W-1:0] source_q;
    logic [TYPE_W-1:0]   type_q;
    logic [CORES-1:0]    to_send_q;
    logic                ack_q;
    logic                proto_err_q;

    logic [CORE_W-1:0]   probe_idx;
    logic                probe_any;
    logic                is_get;
    logic                ack_window;
    logic                req_fire;
    logic                probe_fire;
    logic [CORES-1:0]    to_send_next;

    cpu64_l2_prio_enc #(.N(CORES), .IW(CORE_W)) u_prio_enc (
        .vec   (to_send_q),
        .idx   (probe_idx),
        .valid (probe_any)
    );

    assign is_get       = (type_q == TYPE_W'(OP_GET));
    assign ack_window   = (state_q == ST_PROBE) || (state_q == ST_WAIT_ACK);
    assign req_fire     = (state_q == ST_IDLE) && req_valid_i && mshr_alloc_ready_i;
    assign probe_fire   = probe_valid_o && probe_ready_i;
    assign to_send_next = to_send_q & ~(CORES'(1) << probe_idx);

    // Allocation is forwarded straight from the request in the accept cycle
    assign req_ready_o         = (state_q == ST_IDLE) && mshr_alloc_ready_i;
    assign mshr_alloc_req_o    = req_fire;
    assign mshr_alloc_addr_o   = req_fire ? req_addr_i   : '0;
    assign mshr_alloc_source_o = req_fire ? req_source_i : '0;
    assign mshr_alloc_type_o   = req_fire ? req_type_i   : '0;

    assign mshr_set_probes_o  = (state_q == ST_SETP);
    assign mshr_probes_mask_o = mshr_set_probes_o ? to_send_q : '0;

    // Probe acks pass through untouched while probes can be outstanding
    assign mshr_probe_ack_o    = pack_valid_i && ack_window;
    assign mshr_probe_ack_id_o = mshr_probe_ack_o ? pack_core_i : '0;

    assign probe_valid_o = (state_q == ST_PROBE) && probe_any;
    assign probe_core_o  = probe_valid_o ? probe_idx : '0;
    assign probe_addr_o  = probe_valid_o ? addr_q : '0;
    assign probe_cap_o   = probe_valid_o ? (is_get ? CAP_TOB : CAP_TON) : 2'd0;

    assign grant_valid_o  = (state_q == ST_GRANT);
    assign grant_opcode_o = grant_valid_o ? d_opcode(3'(type_q)) : 3'd0;
    assign grant_source_o = grant_valid_o ? source_q : '0;

    assign mshr_dealloc_req_o = (state_q == ST_FREE);
    assign busy_o             = (state_q != ST_IDLE);
    assign proto_err_o        = proto_err_q;

    // Transaction state machine plus latched request fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            source_q    <= '0;
            type_q      <= '0;
            to_send_q   <= '0;
            ack_q       <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            // ack_q covers the cycle in which the MSHR is still clearing
            // the pending bit of the most recent ack
            ack_q       <= mshr_probe_ack_o;
            proto_err_q <= (pack_valid_i && !ack_window) ||
                           (gack_valid_i && (state_q != ST_WAIT_GACK));
            case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        addr_q    <= req_addr_i;
                        source_q  <= req_source_i;
                        type_q    <= req_type_i;
                        to_send_q <= req_sharers_i & ~(CORES'(1) << req_core_i);
                        state_q   <= ST_SETP;
                    end
                end
                ST_SETP: begin
                    state_q <= (to_send_q != '0) ? ST_PROBE : ST_GRANT;
                end
                ST_PROBE: begin
                    if (probe_fire) begin
                        to_send_q <= to_send_next;
                        if (to_send_next == '0) begin
                            state_q <= ST_WAIT_ACK;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if ((mshr_pending_probes_i == '0) && !pack_valid_i && !ack_q) begin
                        state_q <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (grant_ready_i) begin
                        state_q <= is_get ? ST_FREE : ST_WAIT_GACK;
                    end
                end
                ST_WAIT_GACK: begin
                    if (gack_valid_i) begin
                        state_q <= ST_FREE;
                    end
                end
                ST_FREE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu64_l2_mshr_ctrl.sv
// Directed bench for cpu64_l2_mshr_ctrl with a small MSHR model.
module tb_cpu64_l2_mshr_ctrl;

    localparam int ADDR_W   = 64;
    localparam int SOURCE_W = 6;
    localparam int TYPE_W   = 3;
    localparam int CORES    = 4;
    localparam int CORE_W   = 2;

    logic                clk;
    logic                rst_n;
    logic                req_valid;
    logic                req_ready;
    logic [ADDR_W-1:0]   req_addr;
    logic [SOURCE_W-1:0] req_source;
    logic [TYPE_W-1:0]   req_type;
    logic [CORE_W-1:0]   req_core;
    logic [CORES-1:0]    req_sharers;
    logic                mshr_alloc_ready;
    logic                mshr_alloc_req;
    logic [ADDR_W-1:0]   mshr_alloc_addr;
    logic [SOURCE_W-1:0] mshr_alloc_source;
    logic [TYPE_W-1:0]   mshr_alloc_type;
    logic                mshr_set_probes;
    logic [CORES-1:0]    mshr_probes_mask;
    logic                mshr_probe_ack;
    logic [CORE_W-1:0]   mshr_probe_ack_id;
    logic [CORES-1:0]    mshr_pending;
    logic                mshr_dealloc_req;
    logic                probe_valid;
    logic                probe_ready;
    logic [CORE_W-1:0]   probe_core;
    logic [ADDR_W-1:0]   probe_addr;
    logic [1:0]          probe_cap;
    logic                pack_valid;
    logic [CORE_W-1:0]   pack_core;
    logic                grant_valid;
    logic                grant_ready;
    logic [2:0]          grant_opcode;
    logic [SOURCE_W-1:0] grant_source;
    logic                gack_valid;
    logic                busy;
    logic                proto_err;

    logic                mshr_used;
    int                  n_assert;
    int                  n_fail;

    cpu64_l2_mshr_ctrl #(
        .ADDR_W(ADDR_W), .SOURCE_W(SOURCE_W), .TYPE_W(TYPE_W),
        .CORES(CORES), .CORE_W(CORE_W)
    ) dut (
        .clk                   (clk),
        .rst_n                 (rst_n),
        .req_valid_i           (req_valid),
        .req_ready_o           (req_ready),
        .req_addr_i            (req_addr),
        .req_source_i          (req_source),
        .req_type_i            (req_type),
        .req_core_i            (req_core),
        .req_sharers_i         (req_sharers),
        .mshr_alloc_ready_i    (mshr_alloc_ready),
        .mshr_alloc_req_o      (mshr_alloc_req),
        .mshr_alloc_addr_o     (mshr_alloc_addr),
        .mshr_alloc_source_o   (mshr_alloc_source),
        .mshr_alloc_type_o     (mshr_alloc_type),
        .mshr_set_probes_o     (mshr_set_probes),
        .mshr_probes_mask_o    (mshr_probes_mask),
        .mshr_probe_ack_o      (mshr_probe_ack),
        .mshr_probe_ack_id_o   (mshr_probe_ack_id),
        .mshr_pending_probes_i (mshr_pending),
        .mshr_dealloc_req_o    (mshr_dealloc_req),
        .probe_valid_o         (probe_valid),
        .probe_ready_i         (probe_ready),
        .probe_core_o          (probe_core),
        .probe_addr_o          (probe_addr),
        .probe_cap_o           (probe_cap),
        .pack_valid_i          (pack_valid),
        .pack_core_i           (pack_core),
        .grant_valid_o         (grant_valid),
        .grant_ready_i         (grant_ready),
        .grant_opcode_o        (grant_opcode),
        .grant_source_o        (grant_source),
        .gack_valid_i          (gack_valid),
        .busy_o                (busy),
        .proto_err_o           (proto_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // MSHR model: one entry, pending mask with one-cycle clear latency
    assign mshr_alloc_ready = rst_n && !mshr_used;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mshr_used    <= 1'b0;
            mshr_pending <= '0;
        end else begin
            if (mshr_alloc_req)   mshr_used <= 1'b1;
            if (mshr_dealloc_req) mshr_used <= 1'b0;
            if (mshr_set_probes)     mshr_pending <= mshr_probes_mask;
            else if (mshr_probe_ack) mshr_pending[mshr_probe_ack_id] <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [63:0] a, input logic [5:0] s, input logic [2:0] t,
                            input logic [1:0] c, input logic [3:0] sh);
        req_valid   = 1'b1;
        req_addr    = a;
        req_source  = s;
        req_type    = t;
        req_core    = c;
        req_sharers = sh;
    endtask

    initial begin
        n_assert    = 0;
        n_fail      = 0;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_addr    = '0;
        req_source  = '0;
        req_type    = '0;
        req_core    = '0;
        req_sharers = '0;
        probe_ready = 1'b0;
        pack_valid  = 1'b0;
        pack_core   = '0;
        grant_ready = 1'b0;
        gack_valid  = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_req_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_grant_valid", grant_valid, 0);
        check("rst_probe_valid", probe_valid, 0);
        check("rst_dealloc", mshr_dealloc_req, 0);
        check("rst_proto_err", proto_err, 0);
        rst_n = 1'b1;
        #1;
        check("idle_req_ready", req_ready, 1);

        // Get, no other sharers
        tick();
        send_req(64'h1000, 6'h1A, 3'd4, 2'd0, 4'b0001);
        grant_ready = 1'b1;
        #1;
        check("get_alloc_req", mshr_alloc_req, 1);
        check("get_alloc_addr", mshr_alloc_addr, 64'h1000);
        check("get_alloc_src", mshr_alloc_source, 6'h1A);
        check("get_alloc_type", mshr_alloc_type, 3'd4);
        tick();
        req_valid = 1'b0;
        #1;
        check("get_setp", mshr_set_probes, 1);
        check("get_mask", mshr_probes_mask, 4'b0000);
        check("get_no_probe", probe_valid, 0);
        check("get_busy", busy, 1);
        tick();
        check("get_grant_t2", grant_valid, 1);
        check("get_grant_op", grant_opcode, 3'd1);
        check("get_grant_src", grant_source, 6'h1A);
        tick();
        check("get_dealloc_t3", mshr_dealloc_req, 1);
        check("get_no_gack_wait", grant_valid, 0);
        check("get_ready_t3", req_ready, 0);
        tick();
        check("get_ready_t4", req_ready, 1);
        check("get_dealloc_off", mshr_dealloc_req, 0);
        check("get_idle", busy, 0);

        // AcquireBlock from core 1, sharers 1101, acks 2,0,3
        tick();
        send_req(64'h2000, 6'h05, 3'd6, 2'd1, 4'b1101);
        probe_ready = 1'b1;
        #1;
        check("ab_alloc_type", mshr_alloc_type, 3'd6);
        tick();
        req_valid = 1'b0;
        #1;
        check("ab_setp", mshr_set_probes, 1);
        check("ab_mask", mshr_probes_mask, 4'b1101);
        tick();
        check("ab_p0_valid", probe_valid, 1);
        check("ab_p0_core", probe_core, 0);
        check("ab_p0_cap", probe_cap, 2);
        check("ab_p0_addr", probe_addr, 64'h2000);
        check("ab_pend_1101", mshr_pending, 4'b1101);
        tick();
        check("ab_p1_core", probe_core, 2);
        tick();
        pack_valid = 1'b1;
        pack_core  = 2'd2;
        #1;
        check("ab_p2_core", probe_core, 3);
        check("ab_p2_valid", probe_valid, 1);
        check("ab_ack2_fwd", mshr_probe_ack, 1);
        check("ab_ack2_id", mshr_probe_ack_id, 2);
        tick();
        pack_core = 2'd0;
        #1;
        check("ab_probes_done", probe_valid, 0);
        check("ab_pend_1001", mshr_pending, 4'b1001);
        check("ab_ack0_id", mshr_probe_ack_id, 0);
        tick();
        pack_core = 2'd3;
        #1;
        check("ab_pend_1000", mshr_pending, 4'b1000);
        check("ab_ack3_id", mshr_probe_ack_id, 3);
        tick();
        pack_valid = 1'b0;
        #1;
        check("ab_pend_0000", mshr_pending, 4'b0000);
        check("ab_no_grant_a1", grant_valid, 0);
        tick();
        check("ab_no_grant_a2", grant_valid, 0);
        tick();
        check("ab_grant", grant_valid, 1);
        check("ab_grant_op", grant_opcode, 3'd5);
        check("ab_grant_src", grant_source, 6'h05);
        tick();
        check("ab_wait_gack", busy, 1);
        check("ab_wait_gack_nogrant", grant_valid, 0);
        gack_valid = 1'b1;
        tick();
        gack_valid = 1'b0;
        #1;
        check("ab_dealloc", mshr_dealloc_req, 1);
        check("ab_gack_ok", proto_err, 0);
        tick();
        check("ab_ready", req_ready, 1);

        // AcquireBlock with probe_ready low for the first 3 cycles
        tick();
        send_req(64'h3000, 6'h07, 3'd6, 2'd3, 4'b0101);
        probe_ready = 1'b0;
        tick();
        req_valid = 1'b0;
        #1;
        check("st_mask", mshr_probes_mask, 4'b0101);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("st_hold_valid", probe_valid, 1);
            check("st_hold_core", probe_core, 0);
            check("st_hold_addr", probe_addr, 64'h3000);
        end
        tick();
        probe_ready = 1'b1;
        #1;
        check("st_p0_core", probe_core, 0);
        tick();
        check("st_p1_core", probe_core, 2);
        tick();
        pack_valid = 1'b1;
        pack_core  = 2'd0;
        #1;
        check("st_wait_ack", probe_valid, 0);
        tick();
        pack_core = 2'd2;
        tick();
        pack_valid = 1'b0;
        #1;
        check("st_no_grant_a1", grant_valid, 0);
        tick();
        check("st_no_grant_a2", grant_valid, 0);
        tick();
        check("st_grant", grant_valid, 1);
        check("st_grant_op", grant_opcode, 3'd5);
        tick();
        gack_valid = 1'b1;
        tick();
        gack_valid = 1'b0;
        #1;
        check("st_dealloc", mshr_dealloc_req, 1);
        tick();
        check("st_ready", req_ready, 1);

        // AcquirePerm, stray ProbeAck in WAIT_GACK, stray GrantAck in IDLE
        tick();
        send_req(64'h5000, 6'h11, 3'd7, 2'd2, 4'b0100);
        tick();
        req_valid = 1'b0;
        #1;
        check("ap_mask", mshr_probes_mask, 4'b0000);
        tick();
        check("ap_grant_op", grant_opcode, 3'd4);
        tick();
        pack_valid = 1'b1;
        pack_core  = 2'd0;
        #1;
        check("ap_stray_not_fwd", mshr_probe_ack, 0);
        tick();
        pack_valid = 1'b0;
        #1;
        check("ap_proto_err", proto_err, 1);
        check("ap_still_waiting", busy, 1);
        tick();
        check("ap_proto_err_clr", proto_err, 0);
        gack_valid = 1'b1;
        tick();
        gack_valid = 1'b0;
        #1;
        check("ap_dealloc", mshr_dealloc_req, 1);
        tick();
        check("ap_dealloc_once", mshr_dealloc_req, 0);
        check("ap_ready", req_ready, 1);
        gack_valid = 1'b1;
        tick();
        gack_valid = 1'b0;
        #1;
        check("idle_gack_err", proto_err, 1);

        // Reset while in WAIT_ACK, then a fresh Get
        tick();
        send_req(64'h6000, 6'h02, 3'd6, 2'd0, 4'b0010);
        tick();
        req_valid = 1'b0;
        tick();
        check("rw_probe_core", probe_core, 1);
        tick();
        check("rw_in_wait_ack", busy, 1);
        rst_n = 1'b0;
        #1;
        check("rw_busy", busy, 0);
        check("rw_dealloc", mshr_dealloc_req, 0);
        check("rw_req_ready", req_ready, 0);
        check("rw_probe_valid", probe_valid, 0);
        check("rw_grant_valid", grant_valid, 0);
        tick();
        rst_n = 1'b1;
        #1;
        check("rw_ready_after", req_ready, 1);
        tick();
        send_req(64'h4000, 6'h3F, 3'd4, 2'd3, 4'b0000);
        #1;
        check("rw_get_alloc", mshr_alloc_req, 1);
        check("rw_get_addr", mshr_alloc_addr, 64'h4000);
        tick();
        req_valid = 1'b0;
        tick();
        check("rw_get_grant_op", grant_opcode, 3'd1);
        check("rw_get_grant_src", grant_source, 6'h3F);
        tick();
        check("rw_get_dealloc", mshr_dealloc_req, 1);
        tick();
        check("rw_get_ready", req_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
